// File: rtl/seg_scan_pkg.sv
// Shared constants and types for the multiplexed seven-segment scan driver.
package seg_scan_pkg;

  localparam logic [6:0] SEG_OFF    = 7'h7F;
  localparam logic [3:0] AN_OFF     = 4'b1111;
  localparam int         NUM_DIGITS = 4;

  typedef logic [1:0] digit_idx_t;

  // Active-low one-hot anode pattern selecting a single digit.
  function automatic logic [3:0] an_onehot_n(input digit_idx_t i);
    return ~(4'b0001 << i);
  endfunction

endpackage

// File: rtl/seg_scan_driver_scan_timer.sv
// Slot timer: walks cnt through each digit slot and idx across the four digits.
module scan_timer
  import seg_scan_pkg::*;
#(
  parameter int SCAN_DIV     = 16,
  parameter int BLANK_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  output digit_idx_t idx,
  output logic       slot_start,
  output logic       blank,
  output logic       frame_end
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [CNT_W-1:0] cnt;
  logic             last;

  assign last = (cnt == CNT_W'(SCAN_DIV - 1));

  // Disabling parks the scan at the start so re-enabling always opens with a full blank.
  always_ff @(posedge clk) begin
    if (!rst_n || !enable) begin
      cnt <= '0;
      idx <= '0;
    end else if (last) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign slot_start = (cnt == '0);
  assign blank      = (cnt < CNT_W'(BLANK_CYCLES));
  assign frame_end  = last && (idx == 2'd3);

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed seven-segment driver with anti-ghost blanking and per-digit blink.
module seg_scan_driver
  import seg_scan_pkg::*;
#(
  parameter int SCAN_DIV     = 16,
  parameter int BLANK_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [6:0] dig0,
  input  logic [6:0] dig1,
  input  logic [6:0] dig2,
  input  logic [6:0] dig3,
  input  logic [3:0] blink_mask,
  input  logic       blink_tick,
  output logic [6:0] seg_n,
  output logic [3:0] an_n,
  output logic       frame_done
);

  digit_idx_t idx;
  logic       slot_start;
  logic       blank;
  logic       frame_end;
  logic       ph;
  logic [6:0] cur;
  logic [6:0] dig_p0 [NUM_DIGITS];
  logic [3:0] an_p0;
  logic [6:0] seg_p0;

  scan_timer #(
    .SCAN_DIV     (SCAN_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .idx        (idx),
    .slot_start (slot_start),
    .blank      (blank),
    .frame_end  (frame_end)
  );

  assign dig_p0[0] = dig0;
  assign dig_p0[1] = dig1;
  assign dig_p0[2] = dig2;
  assign dig_p0[3] = dig3;

  // Stage p0: decode current slot state into next anode/segment values.
  always_comb begin
    an_p0  = AN_OFF;
    seg_p0 = SEG_OFF;
    if (enable && !blank) begin
      an_p0 = an_onehot_n(idx);
      if (!(ph && blink_mask[idx]))
        seg_p0 = ~cur;
    end
  end

  // Stage p1: registered outputs; cur is captured once per slot so mid-slot edits wait a frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ph         <= 1'b0;
      cur        <= 7'h00;
      an_n       <= AN_OFF;
      seg_n      <= SEG_OFF;
      frame_done <= 1'b0;
    end else begin
      ph         <= ph ^ blink_tick;
      if (enable && slot_start)
        cur <= dig_p0[idx];
      an_n       <= an_p0;
      seg_n      <= seg_p0;
      frame_done <= enable && frame_end;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: cycle scoreboard plus directed edge checks.
module tb_seg_scan_driver;

  localparam int SCAN_DIV = 16;
  localparam int BLANK    = 4;

  logic       clk = 1'b0;
  logic       rst_n, enable, blink_tick;
  logic [6:0] dig0, dig1, dig2, dig3;
  logic [3:0] blink_mask;
  logic [6:0] seg_n;
  logic [3:0] an_n;
  logic       frame_done;

  seg_scan_driver #(.SCAN_DIV(SCAN_DIV), .BLANK_CYCLES(BLANK)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .dig0(dig0), .dig1(dig1), .dig2(dig2), .dig3(dig3),
    .blink_mask(blink_mask), .blink_tick(blink_tick),
    .seg_n(seg_n), .an_n(an_n), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       fd;
  } exp_t;

  exp_t       q[$];
  int         checks = 0;
  int         errors = 0;
  int         edge_n = 0;
  int         t      = 0;
  logic       mph    = 1'b0;
  logic [6:0] mcur   = 7'h00;
  logic [3:0] prev_an = 4'hF;

  function automatic logic [6:0] dig_sel(input int i);
    case (i)
      0:       return dig0;
      1:       return dig1;
      2:       return dig2;
      default: return dig3;
    endcase
  endfunction

  // One clock edge: predict from the model, advance the model, compare after the edge.
  task automatic step();
    exp_t       e, got;
    int         c, i, lows;
    logic [3:0] onehot;
    e = '{an: 4'hF, seg: 7'h7F, fd: 1'b0};
    if (!rst_n) begin
      t = 0; mph = 1'b0; mcur = 7'h00;
    end else begin
      if (!enable) begin
        t = 0;
      end else begin
        c = t % SCAN_DIV;
        i = (t / SCAN_DIV) % 4;
        if (c >= BLANK) begin
          onehot = 4'b0001 << i;
          e.an   = ~onehot;
          e.seg  = (mph && blink_mask[i]) ? 7'h7F : ~mcur;
        end
        e.fd = (c == SCAN_DIV - 1) && (i == 3);
        if (c == 0) mcur = dig_sel(i);
        t = (t + 1) % (SCAN_DIV * 4);
      end
      if (blink_tick) mph = ~mph;
    end
    q.push_back(e);
    @(posedge clk);
    #1;
    edge_n++;
    got = q.pop_front();
    checks++;
    if ({an_n, seg_n, frame_done} !== got) begin
      errors++;
      $display("FAIL scoreboard edge %0d: got an_n=%b seg_n=%h fd=%b, want an_n=%b seg_n=%h fd=%b",
               edge_n, an_n, seg_n, frame_done, got.an, got.seg, got.fd);
    end
    lows = 0;
    for (int b = 0; b < 4; b++) if (an_n[b] === 1'b0) lows++;
    checks++;
    if (lows > 1 || (prev_an != 4'hF && an_n != 4'hF && an_n != prev_an)) begin
      errors++;
      $display("FAIL anode_overlap edge %0d: got prev=%b now=%b, want no overlap", edge_n, prev_an, an_n);
    end
    prev_an = an_n;
  endtask

  task automatic run_to(input int target);
    while (edge_n < target) step();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n  = 1'b1;
    edge_n = 0;
  endtask

  task automatic expect_out(input string name, input logic [3:0] an_w, input logic [6:0] seg_w);
    checks++;
    if (an_n !== an_w || seg_n !== seg_w) begin
      errors++;
      $display("FAIL %s edge %0d: got an_n=%b seg_n=%h, want an_n=%b seg_n=%h",
               name, edge_n, an_n, seg_n, an_w, seg_w);
    end
  endtask

  task automatic test_reset();
    enable = 1'b1;
    apply_reset();
    checks++;
    if (an_n !== 4'hF || seg_n !== 7'h7F || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got an_n=%b seg_n=%h fd=%b, want 1111 7f 0", an_n, seg_n, frame_done);
    end
  endtask

  task automatic test_basic();
    run_to(4);  expect_out("basic_blank_e4", 4'b1111, 7'h7F);
    run_to(5);  expect_out("basic_d0_e5",    4'b1110, 7'h40);
    run_to(16); expect_out("basic_d0_e16",   4'b1110, 7'h40);
    run_to(17); expect_out("basic_gap_e17",  4'b1111, 7'h7F);
    run_to(20); expect_out("basic_gap_e20",  4'b1111, 7'h7F);
    run_to(21); expect_out("basic_d1_e21",   4'b1101, 7'h79);
    run_to(32); expect_out("basic_d1_e32",   4'b1101, 7'h79);
  endtask

  task automatic test_frame();
    int n = 0, first = -1, second = -1;
    while (edge_n < 130) begin
      step();
      if (frame_done === 1'b1) begin
        n++;
        if (first < 0) first = edge_n; else if (second < 0) second = edge_n;
      end
    end
    checks++;
    if (n != 2 || first != 64 || second != 128) begin
      errors++;
      $display("FAIL frame_done_edges: got count=%0d at %0d,%0d, want 2 at 64,128", n, first, second);
    end
  endtask

  task automatic test_midslot();
    apply_reset();
    run_to(8);
    dig0 = 7'h5B;
    run_to(10); expect_out("midslot_hold_e10", 4'b1110, 7'h40);
    run_to(16); expect_out("midslot_hold_e16", 4'b1110, 7'h40);
    run_to(69); expect_out("midslot_new_e69",  4'b1110, 7'h24);
    dig0 = 7'h3F;
  endtask

  task automatic test_blink();
    apply_reset();
    blink_mask = 4'b0001;
    blink_tick = 1'b1;
    step();
    blink_tick = 1'b0;
    run_to(5);  expect_out("blink_d0_off",  4'b1110, 7'h7F);
    run_to(21); expect_out("blink_d1_on",   4'b1101, 7'h79);
    run_to(37); expect_out("blink_d2_on",   4'b1011, 7'h24);
    run_to(39);
    blink_tick = 1'b1;
    step();
    blink_tick = 1'b0;
    run_to(69); expect_out("blink_d0_back", 4'b1110, 7'h40);
    blink_mask = 4'b0000;
  endtask

  task automatic test_enable();
    int e;
    apply_reset();
    run_to(10);
    enable = 1'b0;
    run_to(11); expect_out("disable_e11", 4'b1111, 7'h7F);
    run_to(20);
    e = edge_n;
    enable = 1'b1;
    run_to(e + BLANK);     expect_out("reenable_blank", 4'b1111, 7'h7F);
    run_to(e + BLANK + 1); expect_out("reenable_lit",   4'b1110, 7'h40);
  endtask

  task automatic test_reset_mid();
    apply_reset();
    run_to(40);
    expect_out("pre_reset_d2", 4'b1011, 7'h24);
    rst_n = 1'b0;
    blink_tick = 1'b1;
    step();
    blink_tick = 1'b0;
    checks++;
    if (an_n !== 4'hF || seg_n !== 7'h7F || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL midreset_off: got an_n=%b seg_n=%h fd=%b, want 1111 7f 0", an_n, seg_n, frame_done);
    end
    rst_n  = 1'b1;
    edge_n = 0;
    run_to(4);  expect_out("after_reset_e4",  4'b1111, 7'h7F);
    run_to(5);  expect_out("after_reset_e5",  4'b1110, 7'h40);
    run_to(16); expect_out("after_reset_e16", 4'b1110, 7'h40);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; blink_tick = 1'b0; blink_mask = 4'b0000;
    dig0 = 7'h3F; dig1 = 7'h06; dig2 = 7'h5B; dig3 = 7'h4F;
    test_reset();
    test_basic();
    test_frame();
    test_midslot();
    test_blink();
    test_enable();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
